// File: rtl/div_seq_if.sv
// Handshake bundle between the EXE stage and the sequential divider.
// master: EXE-stage side driving requests; slave: the divider.
interface div_seq_if #(
  parameter int unsigned DATA_W = 32
);
  logic              div_req;
  logic              div_signed;
  logic [DATA_W-1:0] div_src1;
  logic [DATA_W-1:0] div_src2;
  logic              div_ack;
  logic              div_flush;
  logic              div_stall;
  logic              div_done;
  logic [DATA_W-1:0] div_quot;
  logic [DATA_W-1:0] div_rem;

  modport master (
    output div_req, div_signed, div_src1, div_src2, div_ack, div_flush,
    input  div_stall, div_done, div_quot, div_rem
  );

  modport slave (
    input  div_req, div_signed, div_src1, div_src2, div_ack, div_flush,
    output div_stall, div_done, div_quot, div_rem
  );
endinterface

// File: rtl/div_seq.sv
// Sequential restoring divider for DIV/DIVU in the EXE stage.
// One shift-subtract step per cycle on operand magnitudes; the sign fix-up
// is folded into the edge that completes the final iteration.
module div_seq #(
  parameter int unsigned DATA_W = 32
) (
  input  logic      clk,
  input  logic      reset,
  div_seq_if.slave  bus
);

  localparam int unsigned     CNT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] dvd_q;      // dividend magnitude, shifts left, collects quotient bits
  logic [DATA_W-1:0] part_q;     // partial remainder
  logic [DATA_W-1:0] dsr_q;      // divisor magnitude
  logic [DATA_W-1:0] src1_q;     // dividend as latched, returned as remainder on divide-by-zero
  logic              sign1_q;    // remainder takes the dividend sign
  logic              neg_quot_q; // quotient negated when operand signs differ
  logic [DATA_W-1:0] quot_q;
  logic [DATA_W-1:0] rem_q;

  logic              accept;
  logic              last_iter;
  logic              src1_neg;
  logic              src2_neg;
  logic [DATA_W-1:0] abs1;
  logic [DATA_W-1:0] abs2;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   trial;
  logic              qbit;
  logic [DATA_W-1:0] part_nx;
  logic [DATA_W-1:0] dvd_nx;
  logic [DATA_W-1:0] quot_fix;
  logic [DATA_W-1:0] rem_fix;

  // Accept / last-iteration qualifiers and operand magnitudes.
  always_comb begin
    accept    = (state_q == IDLE) && bus.div_req && !bus.div_flush;
    last_iter = (state_q == CALC) && (cnt_q == LAST_ITER);
    src1_neg  = bus.div_signed && bus.div_src1[DATA_W-1];
    src2_neg  = bus.div_signed && bus.div_src2[DATA_W-1];
    abs1      = src1_neg ? ('0 - bus.div_src1) : bus.div_src1;
    abs2      = src2_neg ? ('0 - bus.div_src2) : bus.div_src2;
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.div_req) state_d = CALC;
      CALC:    if (last_iter)   state_d = DONE;
      DONE:    if (bus.div_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.div_flush) state_d = IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // One restoring step plus the final sign / divide-by-zero fix-up.
  // The fix-up operates on this step's results so the last iteration and
  // the correction share one edge.
  always_comb begin
    shifted = {part_q, dvd_q[DATA_W-1]};
    trial   = shifted - {1'b0, dsr_q};
    qbit    = ~trial[DATA_W];
    part_nx = qbit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
    dvd_nx  = {dvd_q[DATA_W-2:0], qbit};
    if (dsr_q == '0) begin
      quot_fix = '1;
      rem_fix  = src1_q;
    end else begin
      quot_fix = neg_quot_q ? ('0 - dvd_nx)  : dvd_nx;
      rem_fix  = sign1_q    ? ('0 - part_nx) : part_nx;
    end
  end

  // Operand latch, iteration datapath and result registers.
  // The sign flags already include div_signed, so the mode itself is not kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      dvd_q      <= '0;
      part_q     <= '0;
      dsr_q      <= '0;
      src1_q     <= '0;
      sign1_q    <= 1'b0;
      neg_quot_q <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
    end else if (bus.div_flush) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q      <= '0;
      dvd_q      <= abs1;
      part_q     <= '0;
      dsr_q      <= abs2;
      src1_q     <= bus.div_src1;
      sign1_q    <= src1_neg;
      neg_quot_q <= src1_neg ^ src2_neg;
    end else if (state_q == CALC) begin
      dvd_q  <= dvd_nx;
      part_q <= part_nx;
      if (last_iter) begin
        cnt_q  <= '0;
        quot_q <= quot_fix;
        rem_q  <= rem_fix;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Handshake outputs.
  always_comb begin
    bus.div_stall = bus.div_req && (state_q != DONE);
    bus.div_done  = (state_q == DONE);
    bus.div_quot  = quot_q;
    bus.div_rem   = rem_q;
  end

endmodule
